// File: rtl/me_ctrl_pkg.sv
// me_ctrl_pkg: constants and types shared by the craft motion controller.
//   - Direction codes UP/DOWN/LEFT/RIGHT. Other blocks read direct_o using
//     these codes, so they are defined here and nowhere else.
//   - Default timing constants: 20 ms debounce and a 5 ms repeat at 50 MHz.
//   - FSM state type and small helper functions.
package me_ctrl_pkg;

    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] DOWN  = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] RIGHT = 2'd3;

    localparam int DEF_DEBOUNCE_CNT = 1_000_000;
    localparam int DEF_MOVE_PERIOD  = 250_000;
    localparam int DEF_FAST_PERIOD  = 125_000;
    localparam int DEF_ACCEL_STEPS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // Width that holds every value in 0..max(a,b,c)-1, with a minimum of 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Key vector is {right, left, down, up}. Lower index has higher priority.
    function automatic logic [1:0] resolve_dir(input logic [3:0] keys);
        if (keys[0])      return UP;
        else if (keys[1]) return DOWN;
        else if (keys[2]) return LEFT;
        else              return RIGHT;
    endfunction

endpackage

// File: rtl/me_ctrl_key_debounce.sv
// key_debounce: two-flop synchroniser followed by a debounce counter for a
// single raw push-button.
//   clk, rst : system clock, asynchronous active-low reset
//   key_raw  : raw button input, asynchronous to clk, active-high
//   key_db   : debounced level. It changes only after the synchronised input
//              has disagreed with it for DEBOUNCE_CNT consecutive cycles.
module key_debounce
    import me_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_db
);

    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // NOTE: non-blocking assignments let every flop sample its pre-edge
    // inputs. With blocking assignments the two synchroniser stages would
    // collapse into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            key_db <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_raw};
            if (sync_q[1] == key_db) begin
                // Any agreeing sample restarts the stability count.
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
                key_db <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/me_ctrl.sv
// me_ctrl: player-craft motion controller.
// Debounces the four direction keys and resolves them to one direction, with
// priority UP > DOWN > LEFT > RIGHT. While a key is held, the block issues
// single-cycle move strobes at a fixed repeat rate. The craft's `moving`
// feedback is used to flag strobes that the craft rejected at a boundary.
//   clk, rst          : system clock, asynchronous active-low reset
//   key_*_i           : raw direction buttons, asynchronous to clk
//   pause_i           : freezes the repeat counter, the direction and strobes
//   moving_i          : craft "moved" flag, sampled two cycles after a strobe
//   move_en_o         : single-cycle move strobe
//   direct_o          : direction code, held between strobes
//   held_o            : a debounced key is being serviced
//   blocked_o         : the most recent strobe was rejected by the craft
// Build option: define ME_CTRL_ACCEL_EN to switch the repeat period to
// FAST_PERIOD after ACCEL_STEPS consecutive accepted strobes.
module me_ctrl
    import me_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int MOVE_PERIOD  = DEF_MOVE_PERIOD,
    parameter int FAST_PERIOD  = DEF_FAST_PERIOD,
    parameter int ACCEL_STEPS  = DEF_ACCEL_STEPS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up_i,
    input  logic       key_down_i,
    input  logic       key_left_i,
    input  logic       key_right_i,
    input  logic       pause_i,
    input  logic       moving_i,
    output logic       move_en_o,
    output logic [1:0] direct_o,
    output logic       held_o,
    output logic       blocked_o
);

    localparam int CNT_W = cnt_width(MOVE_PERIOD, FAST_PERIOD, ACCEL_STEPS + 1);
    // The counter is loaded with period-1 and a strobe fires when it reads 0,
    // so consecutive strobes are exactly one period apart.
    localparam logic [CNT_W-1:0] MOVE_RELOAD = CNT_W'(MOVE_PERIOD - 1);

    logic [3:0] keys_raw;
    logic [3:0] keys_db;

    assign keys_raw = {key_right_i, key_left_i, key_down_i, key_up_i};

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .key_raw(keys_raw[i]),
            .key_db (keys_db[i])
        );
    end

    state_t           state_q, state_d;
    state_t           resume_q, resume_d;
    state_t           eff_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] reload_val;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       res_dir;
    logic             move_en_q, move_en_d;
    logic             blocked_q;
    logic [1:0]       strobe_pipe_q;
    logic             any_key;
    logic             dir_chg;

    assign any_key   = |keys_db;
    assign res_dir   = resolve_dir(keys_db);
    // On the first unpaused cycle the FSM acts as the state it was paused in.
    assign eff_state = (state_q == ST_PAUSED) ? resume_q : state_q;
    // A direction change waits one cycle if a strobe was just issued, so
    // that move_en_o never stays high on two consecutive cycles.
    assign dir_chg   = !move_en_q && (res_dir != dir_q);

`ifdef ME_CTRL_ACCEL_EN
    localparam logic [CNT_W-1:0] FAST_RELOAD = CNT_W'(FAST_PERIOD - 1);

    logic [CNT_W-1:0] accel_q;
    logic             accel_clr;

    // Cleared on entry to HOLD, on release, and on a direction change.
    assign accel_clr  = !pause_i && ((eff_state == ST_IDLE) ? any_key : (!any_key || dir_chg));
    assign reload_val = (accel_q == CNT_W'(ACCEL_STEPS)) ? FAST_RELOAD : MOVE_RELOAD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accel_q <= '0;
        end else if (accel_clr) begin
            accel_q <= '0;
        end else if (strobe_pipe_q[1]) begin
            if (!moving_i)
                accel_q <= '0;
            else if (accel_q != CNT_W'(ACCEL_STEPS))
                accel_q <= accel_q + CNT_W'(1);
        end
    end
`else
    assign reload_val = MOVE_RELOAD;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            resume_q      <= ST_IDLE;
            cnt_q         <= '0;
            dir_q         <= UP;
            move_en_q     <= 1'b0;
            blocked_q     <= 1'b0;
            strobe_pipe_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            move_en_q     <= move_en_d;
            strobe_pipe_q <= {strobe_pipe_q[0], move_en_q};
            // moving_i is sampled two cycles after the strobe cycle.
            if (strobe_pipe_q[1])
                blocked_q <= !moving_i;
        end
    end

    // NOTE: every signal driven here gets a default first. If some path
    // skipped an assignment, synthesis would infer a latch.
    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        move_en_d = 1'b0;

        if (pause_i) begin
            state_d = ST_PAUSED;
            if (state_q != ST_PAUSED)
                resume_d = state_q;
        end else if (eff_state == ST_IDLE) begin
            state_d = ST_IDLE;
            if (any_key) begin
                state_d   = ST_HOLD;
                move_en_d = 1'b1;
                dir_d     = res_dir;
                cnt_d     = MOVE_RELOAD;
            end
        end else begin
            state_d = ST_HOLD;
            if (!any_key) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (dir_chg) begin
                // A direction change takes priority over a periodic strobe.
                move_en_d = 1'b1;
                dir_d     = res_dir;
                cnt_d     = MOVE_RELOAD;
            end else if (!move_en_q && cnt_q == '0) begin
                move_en_d = 1'b1;
                cnt_d     = reload_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign move_en_o = move_en_q;
    assign direct_o  = dir_q;
    assign held_o    = (eff_state == ST_HOLD);
    assign blocked_o = blocked_q;

endmodule

// File: tb/tb_me_ctrl.sv
// Self-checking bench for me_ctrl with DEBOUNCE_CNT=4, MOVE_PERIOD=8,
// FAST_PERIOD=4, ACCEL_STEPS=3. A cycle-level behavioural model, built from
// raw-sample history and elapsed-cycle counts, is compared with the DUT on
// every falling edge. Directed scenarios add hand-computed latencies.
module tb_me_ctrl;
    import me_ctrl_pkg::*;

    localparam int DEB = 4;
    localparam int MP  = 8;
    localparam int FP  = 4;
    localparam int AS  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] keys = 4'b0000;   // {right, left, down, up}
    logic       pause = 1'b0;
    logic       moving = 1'b1;
    logic       move_en;
    logic [1:0] direct;
    logic       held;
    logic       blocked;

    always #5 clk = ~clk;

    me_ctrl #(
        .DEBOUNCE_CNT(DEB),
        .MOVE_PERIOD (MP),
        .FAST_PERIOD (FP),
        .ACCEL_STEPS (AS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_up_i   (keys[0]),
        .key_down_i (keys[1]),
        .key_left_i (keys[2]),
        .key_right_i(keys[3]),
        .pause_i    (pause),
        .moving_i   (moving),
        .move_en_o  (move_en),
        .direct_o   (direct),
        .held_o     (held),
        .blocked_o  (blocked)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] rawq[$];      // raw key samples, newest first
    int         strobe_at[$]; // edge numbers of strobes still waiting for feedback
    logic [3:0] m_deb;
    bit         m_hold, m_strobe, m_blocked;
    int         m_dir, m_elapsed, m_period, m_accel, m_n;

    function automatic int model_dir(input logic [3:0] k);
        int code[4];
        int d;
        code = '{int'(UP), int'(DOWN), int'(LEFT), int'(RIGHT)};
        d = code[3];
        for (int i = 3; i >= 0; i--) if (k[i]) d = code[i];
        return d;
    endfunction

    task automatic model_step();
        int         accel_pre;
        bit         prev;
        bit         any;
        int         rdir;
        logic [3:0] deb;
        accel_pre = m_accel;
        prev      = m_strobe;
        deb       = m_deb;
        any       = (deb != 4'b0000);
        rdir      = model_dir(deb);
        m_n++;
        rawq.push_front(keys);
        void'(rawq.pop_back());
        // Feedback for the strobe issued three edges ago.
        if (strobe_at.size() > 0 && strobe_at[0] == m_n - 3) begin
            void'(strobe_at.pop_front());
            if (moving) begin
                m_blocked = 1'b0;
                if (m_accel < AS) m_accel++;
            end else begin
                m_blocked = 1'b1;
                m_accel   = 0;
            end
        end
        m_strobe = 1'b0;
        if (!pause) begin
            if (!m_hold) begin
                if (any) begin
                    m_strobe = 1'b1; m_dir = rdir; m_hold = 1'b1;
                    m_elapsed = 0; m_period = MP; m_accel = 0;
                end
            end else if (!any) begin
                m_hold = 1'b0; m_accel = 0;
            end else if (!prev && rdir != m_dir) begin
                m_strobe = 1'b1; m_dir = rdir;
                m_elapsed = 0; m_period = MP; m_accel = 0;
            end else begin
                m_elapsed++;
                if (!prev && m_elapsed >= m_period) begin
                    m_strobe = 1'b1; m_elapsed = 0;
`ifdef ME_CTRL_ACCEL_EN
                    m_period = (accel_pre == AS) ? FP : MP;
`else
                    m_period = MP;
`endif
                end
            end
        end
        if (m_strobe) strobe_at.push_back(m_n);
        // A key flips once the DEB synchronised samples seen at this edge
        // (raw samples 2..DEB+1 edges old) all disagree with it.
        for (int j = 0; j < 4; j++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int i = 2; i <= DEB + 1; i++) if (rawq[i][j] == m_deb[j]) all_diff = 1'b0;
            if (all_diff) m_deb[j] = ~m_deb[j];
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rawq = {};
            for (int i = 0; i < DEB + 2; i++) rawq.push_back(4'b0000);
            strobe_at = {};
            m_deb = 4'b0000; m_hold = 1'b0; m_strobe = 1'b0; m_blocked = 1'b0;
            m_dir = int'(UP); m_elapsed = 0; m_period = MP; m_accel = 0; m_n = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("move_en_o", int'(move_en), int'(m_strobe));
            check("direct_o",  int'(direct),  m_dir);
            check("held_o",    int'(held),    int'(m_hold));
            check("blocked_o", int'(blocked), int'(m_blocked));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check({tag, "_rst_move_en"}, int'(move_en), 0);
        check({tag, "_rst_direct"},  int'(direct),  int'(UP));
        check({tag, "_rst_held"},    int'(held),    0);
        check({tag, "_rst_blocked"}, int'(blocked), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // Counts falling edges until move_en_o is seen high (at least one edge).
    task automatic wait_strobe(input int max_cyc, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!move_en && k < max_cyc);
        if (!move_en) begin
            check("strobe_timeout", 0, 1);
            k = -1;
        end
    endtask

    task automatic count_strobes(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (move_en) cnt++;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;

        // Hold RIGHT: first strobe after 2+4+1 cycles, then every 8.
        do_reset("right");
        @(negedge clk); keys = 4'b1000;
        wait_strobe(30, k);
        check("right_first_latency", k, 7);
        check("right_dir", int'(direct), int'(RIGHT));
        check("right_held", int'(held), 1);
        for (int i = 0; i < 3; i++) begin
            wait_strobe(30, k);
            check("right_period", k, 8);
        end
        keys = 4'b0000;
        repeat (12) @(negedge clk);

        // A 3-cycle glitch on UP never gets through the debouncer.
        do_reset("glitch");
        @(negedge clk); keys = 4'b0001;
        repeat (3) @(negedge clk);
        keys = 4'b0000;
        count_strobes(15, n);
        check("glitch_strobes", n, 0);
        check("glitch_held", int'(held), 0);

        // LEFT, then UP added: direction-change strobe, then regular period.
        do_reset("left_up");
        @(negedge clk); keys = 4'b0100;
        wait_strobe(30, k);
        check("left_first_latency", k, 7);
        check("left_dir", int'(direct), int'(LEFT));
        keys = 4'b0101;
        wait_strobe(30, k);
        check("up_change_latency", k, 7);
        check("up_change_dir", int'(direct), int'(UP));
        wait_strobe(30, k);
        check("up_after_change_period", k, 8);
        keys = 4'b0000;
        repeat (6) @(negedge clk);
        check("release_held_still", int'(held), 1);
        @(negedge clk);
        check("release_held_fall", int'(held), 0);
        count_strobes(20, n);
        check("release_strobes", n, 0);

        // DOWN with the craft stuck at a boundary.
        do_reset("blocked");
        moving = 1'b0;
        @(negedge clk); keys = 4'b0010;
        wait_strobe(30, k);
        check("down_dir", int'(direct), int'(DOWN));
        check("blocked_at_strobe", int'(blocked), 0);
        repeat (2) @(negedge clk);
        check("blocked_pre", int'(blocked), 0);
        @(negedge clk);
        check("blocked_set", int'(blocked), 1);
        wait_strobe(30, k);
        check("blocked_next_strobe", k, 5);
        wait_strobe(30, k);
        check("blocked_period", k, 8);
        moving = 1'b1;
        keys = 4'b0000;
        repeat (12) @(negedge clk);

`ifdef ME_CTRL_ACCEL_EN
        // Acceleration: three accepted strobes, then period 4; a blocked
        // strobe restores period 8.
        begin
            int exp_gap[5];
            exp_gap = '{8, 8, 8, 4, 4};
            do_reset("accel");
            @(negedge clk); keys = 4'b0001;
            wait_strobe(30, k);
            for (int i = 0; i < 5; i++) begin
                wait_strobe(30, k);
                check("accel_gap", k, exp_gap[i]);
            end
            moving = 1'b0;
            wait_strobe(30, k);
            check("accel_gap_last_fast", k, 4);
            wait_strobe(30, k);
            check("accel_gap_restored", k, 8);
            moving = 1'b1;
            keys = 4'b0000;
            repeat (12) @(negedge clk);
        end
`endif

        // Pause for 20 cycles mid-period: the counter resumes where it was.
        do_reset("pause");
        @(negedge clk); keys = 4'b1000;
        wait_strobe(30, k);
        repeat (3) @(negedge clk);
        pause = 1'b1;
        count_strobes(20, n);
        check("pause_strobes", n, 0);
        check("pause_held", int'(held), 1);
        pause = 1'b0;
        wait_strobe(30, k);
        check("pause_resume_gap", k, 5);
        wait_strobe(30, k);
        check("pause_after_period", k, 8);

        // Reset mid-hold with RIGHT still pressed.
        repeat (3) @(negedge clk);
        do_reset("midhold");
        wait_strobe(30, k);
        check("midhold_first_latency", k, 7);
        check("midhold_dir", int'(direct), int'(RIGHT));

        // Randomised traffic against the model.
        keys = 4'b0000;
        do_reset("random");
        repeat (80) begin
            keys  = 4'($urandom_range(0, 15));
            pause = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, 40)) begin
                @(negedge clk);
                moving = ($urandom_range(0, 3) != 0);
            end
        end
        keys  = 4'b0000;
        pause = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
